// File: rtl/shift_reg_pkg.sv
// shift_reg_pkg: shared definitions for the shift_reg_seq register/shifter.
//   op_e         - operation codes driven on the op port
//   state_e      - sequencer states
//   amt_width()  - width of the shift-amount port for a given register width
//   is_shift_op()- true for ops that run as a multi-cycle step sequence
// Optional feature macro: SHIFT_REG_ROTATE_EN (enables ROTL/ROTR).
package shift_reg_pkg;

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_LOAD = 3'b001,
    OP_SHL  = 3'b010,
    OP_SHR  = 3'b011,
    OP_ASR  = 3'b100,
    OP_ROTL = 3'b101,
    OP_ROTR = 3'b110,
    OP_RSVD = 3'b111
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  function automatic int unsigned amt_width(input int unsigned width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

  // Rotates only count as sequenced ops when the rotate logic is built;
  // otherwise they fall back to HOLD behaviour.
  function automatic logic is_shift_op(input op_e o);
    logic r;
    r = 1'b0;
    case (o)
      OP_SHL, OP_SHR, OP_ASR: r = 1'b1;
`ifdef SHIFT_REG_ROTATE_EN
      OP_ROTL, OP_ROTR:       r = 1'b1;
`endif
      default:                r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/shift_reg_step.sv
// shift_reg_step: purely combinational one-bit step of a shift/rotate op.
// Ports:
//   q       in  WIDTH  current register contents
//   op      in  op_e   operation to step (non-shift ops pass q through)
//   ser_in  in  1      fill bit for SHL/SHR
//   q_next  out WIDTH  register contents after one step
//   out_bit out 1      bit leaving the register on this step
// Optional feature macro: SHIFT_REG_ROTATE_EN (builds ROTL/ROTR paths).
module shift_reg_step
  import shift_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] q,
  input  op_e              op,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q_next,
  output logic             out_bit
);

  always_comb begin
    q_next  = q;
    out_bit = 1'b0;
    case (op)
      OP_SHL: begin
        q_next  = {q[WIDTH-2:0], ser_in};
        out_bit = q[WIDTH-1];
      end
      OP_SHR: begin
        q_next  = {ser_in, q[WIDTH-1:1]};
        out_bit = q[0];
      end
      OP_ASR: begin
        q_next  = {q[WIDTH-1], q[WIDTH-1:1]};
        out_bit = q[0];
      end
`ifdef SHIFT_REG_ROTATE_EN
      OP_ROTL: begin
        q_next  = {q[WIDTH-2:0], q[WIDTH-1]};
        out_bit = q[WIDTH-1];
      end
      OP_ROTR: begin
        q_next  = {q[0], q[WIDTH-1:1]};
        out_bit = q[0];
      end
`endif
      default: begin
        q_next  = q;
        out_bit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_reg_seq.sv
// shift_reg_seq: WIDTH-bit register with parallel load and multi-cycle
// shift/rotate sequencing under a start/busy/done handshake.
// Ports:
//   clk      in  1      rising-edge clock
//   resetn   in  1      synchronous active-low reset
//   start    in  1      request, sampled only while busy=0
//   op       in  3      operation code (see shift_reg_pkg::op_e)
//   amt      in  AMT_W  shift count 0..WIDTH-1
//   D        in  WIDTH  parallel load data
//   ser_in   in  1      serial fill bit for SHL/SHR, sampled every step
//   Q        out WIDTH  register contents
//   Qnot     out WIDTH  ~Q, combinational
//   ser_out  out 1      last bit shifted/rotated out (registered)
//   busy     out 1      multi-cycle shift in progress
//   done     out 1      one-cycle completion pulse
// Optional feature macro: SHIFT_REG_ROTATE_EN (op 101/110 rotate; otherwise
// they act as HOLD).
module shift_reg_seq
  import shift_reg_pkg::*;
#(
  parameter  int unsigned WIDTH = 16,
  localparam int unsigned AMT_W = amt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] D,
  input  logic             ser_in,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qnot,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  state_e           state, state_nx;
  op_e              op_lat, op_lat_nx;
  logic [AMT_W-1:0] remaining, remaining_nx;
  logic [WIDTH-1:0] q_nx;
  logic             ser_out_nx, busy_nx, done_nx;

  logic [WIDTH-1:0] step_q;
  logic             step_bit;
  op_e              op_in;

  assign op_in = op_e'(op);
  assign Qnot  = ~Q;

  shift_reg_step #(.WIDTH(WIDTH)) u_step (
    .q       (Q),
    .op      (op_lat),
    .ser_in  (ser_in),
    .q_next  (step_q),
    .out_bit (step_bit)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      op_lat    <= OP_HOLD;
      remaining <= '0;
      Q         <= '0;
      ser_out   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      op_lat    <= op_lat_nx;
      remaining <= remaining_nx;
      Q         <= q_nx;
      ser_out   <= ser_out_nx;
      busy      <= busy_nx;
      done      <= done_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    op_lat_nx    = op_lat;
    remaining_nx = remaining;
    q_nx         = Q;
    ser_out_nx   = ser_out;
    busy_nx      = busy;
    done_nx      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (is_shift_op(op_in) && (amt != '0)) begin
            // Acceptance edge only latches; the first step is the next edge.
            op_lat_nx    = op_in;
            remaining_nx = amt;
            busy_nx      = 1'b1;
            state_nx     = ST_SHIFT;
          end else begin
            done_nx = 1'b1;
            if (op_in == OP_LOAD) q_nx = D;
          end
        end
      end
      ST_SHIFT: begin
        q_nx         = step_q;
        ser_out_nx   = step_bit;
        remaining_nx = remaining - 1'b1;
        if (remaining == AMT_W'(1)) begin
          state_nx = ST_IDLE;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_shift_reg_seq.sv
// tb_shift_reg_seq: self-checking bench for shift_reg_seq. A behavioural
// model computes the end result of each operation with whole-word arithmetic.
// Honours SHIFT_REG_ROTATE_EN the same way as the design.
module tb_shift_reg_seq;

  localparam int unsigned W  = 16;
  localparam int unsigned AW = $clog2(W);

  logic          clk = 1'b0;
  logic          resetn, start, ser_in;
  logic [2:0]    op;
  logic [AW-1:0] amt;
  logic [W-1:0]  D, Q, Qnot;
  logic          ser_out, busy, done;

  int vectors     = 0;
  int miscompares = 0;

  logic [W-1:0] q_m;
  logic         so_m;

  always #5 clk = ~clk;

  shift_reg_seq #(.WIDTH(W)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .start   (start),
    .op      (op),
    .amt     (amt),
    .D       (D),
    .ser_in  (ser_in),
    .Q       (Q),
    .Qnot    (Qnot),
    .ser_out (ser_out),
    .busy    (busy),
    .done    (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit model_multi(input logic [2:0] o, input int n);
    bit sh;
    sh = (o == 3'd2) || (o == 3'd3) || (o == 3'd4);
`ifdef SHIFT_REG_ROTATE_EN
    sh = sh || (o == 3'd5) || (o == 3'd6);
`endif
    return sh && (n != 0);
  endfunction

  // Returns {ser_out, Q} after the whole operation; pat[i] is ser_in at step i.
  function automatic logic [W:0] model_result(input logic [2:0] o, input int n,
      input logic [W-1:0] q, input logic [W-1:0] d, input logic so,
      input logic [15:0] pat);
    logic [W-1:0] fill_l, fill_r, res_q;
    logic signed [W-1:0] s;
    logic res_so;
    fill_l = '0;
    fill_r = '0;
    for (int i = 0; i < n; i++) begin
      fill_l = fill_l | (W'(pat[i]) << (n - 1 - i));
      fill_r = fill_r | (W'(pat[i]) << (W - n + i));
    end
    res_q  = (o == 3'd1) ? d : q;
    res_so = so;
    if (model_multi(o, n)) begin
      case (o)
        3'd2: begin res_q = (q << n) | fill_l; res_so = q[W-n]; end
        3'd3: begin res_q = (q >> n) | fill_r; res_so = q[n-1]; end
        3'd4: begin s = $signed(q) >>> n; res_q = s; res_so = q[n-1]; end
        3'd5: begin res_q = (q << n) | (q >> (W - n)); res_so = q[W-n]; end
        3'd6: begin res_q = (q >> n) | (q << (W - n)); res_so = q[n-1]; end
        default: ;
      endcase
    end
    return {res_so, res_q};
  endfunction

  // Issues one request and follows it to completion, checking the handshake.
  task automatic do_op(input string tag, input logic [2:0] o, input int n,
      input logic [W-1:0] d, input logic [15:0] pat, input bit inject);
    logic [W:0] exp;
    int cnt;
    exp = model_result(o, n, q_m, d, so_m, pat);
    op = o; amt = AW'(n); D = d; ser_in = pat[0]; start = 1'b1;
    tick();
    start = 1'b0; op = 3'($urandom); amt = AW'($urandom); D = W'($urandom);
    if (model_multi(o, n)) begin
      vectors++;
      if (busy !== 1'b1 || done !== 1'b0 || Q !== q_m) begin
        miscompares++;
        $display("FAIL %s_accept: busy=%b done=%b Q=%h want busy=1 done=0 Q=%h", tag, busy, done, Q, q_m);
      end
      cnt = 1;
      for (int i = 0; i < int'(W) + 2; i++) begin
        if (inject && cnt == 2) begin start = 1'b1; op = 3'd1; D = W'($urandom); end
        tick();
        start = 1'b0;
        if (!busy) break;
        ser_in = pat[cnt % 16];
        cnt++;
      end
      vectors++;
      if (cnt != n) begin
        miscompares++;
        $display("FAIL %s_busy_len: got %0d want %0d", tag, cnt, n);
      end
    end
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_done: done=%b busy=%b want done=1 busy=0", tag, done, busy);
    end
    vectors++;
    if (Q !== exp[W-1:0] || Qnot !== ~exp[W-1:0]) begin
      miscompares++;
      $display("FAIL %s_q: Q=%h Qnot=%h want Q=%h", tag, Q, Qnot, exp[W-1:0]);
    end
    vectors++;
    if (ser_out !== exp[W]) begin
      miscompares++;
      $display("FAIL %s_ser_out: got %b want %b", tag, ser_out, exp[W]);
    end
    q_m  = exp[W-1:0];
    so_m = exp[W];
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b1; op = 3'd1; D = 16'hFFFF; amt = '0; ser_in = 1'b1;
    tick();
    tick();
    vectors++;
    if (Q !== 16'h0000 || Qnot !== 16'hFFFF || busy !== 1'b0 || done !== 1'b0 || ser_out !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: Q=%h Qnot=%h busy=%b done=%b ser_out=%b want 0000 FFFF 0 0 0", Q, Qnot, busy, done, ser_out);
    end
    q_m = '0; so_m = 1'b0;
    resetn = 1'b1; start = 1'b0;
  endtask

  task automatic test_load();
    do_op("load", 3'd1, 0, 16'hA5C3, 16'h0000, 1'b0);
    vectors++;
    if (Qnot !== 16'h5A3C) begin
      miscompares++;
      $display("FAIL load_qnot: got %h want 5a3c", Qnot);
    end
    tick();
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || Q !== 16'hA5C3) begin
      miscompares++;
      $display("FAIL load_after: done=%b busy=%b Q=%h want 0 0 a5c3", done, busy, Q);
    end
  endtask

  task automatic test_shl();
    do_op("shl", 3'd2, 4, 16'h0000, 16'hFFFF, 1'b1);
    vectors++;
    if (Q !== 16'h5C3F || ser_out !== 1'b0) begin
      miscompares++;
      $display("FAIL shl_const: Q=%h ser_out=%b want 5c3f 0", Q, ser_out);
    end
    tick();
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL shl_done_width: done=%b want 0", done);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] d;
    do_op("load8004", 3'd1, 0, 16'h8004, 16'h0000, 1'b0);
    do_op("asr", 3'd4, 3, 16'h0000, 16'h0000, 1'b0);
    vectors++;
    if (Q !== 16'hF000 || ser_out !== 1'b1) begin
      miscompares++;
      $display("FAIL asr_const: Q=%h ser_out=%b want f000 1", Q, ser_out);
    end
    d = W'($urandom);
    do_op("b2b_load", 3'd1, 0, d, 16'h0000, 1'b0);
    vectors++;
    if (Q !== d) begin
      miscompares++;
      $display("FAIL b2b_const: Q=%h want %h", Q, d);
    end
  endtask

  task automatic test_reset_mid();
    do_op("loadffff", 3'd1, 0, 16'hFFFF, 16'h0000, 1'b0);
    op = 3'd3; amt = AW'(15); ser_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    vectors++;
    if (busy !== 1'b1 || Q !== 16'h0FFF) begin
      miscompares++;
      $display("FAIL midrst_pre: busy=%b Q=%h want 1 0fff", busy, Q);
    end
    resetn = 1'b0;
    tick();
    vectors++;
    if (Q !== 16'h0000 || busy !== 1'b0 || done !== 1'b0 || ser_out !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst: Q=%h busy=%b done=%b ser_out=%b want 0000 0 0 0", Q, busy, done, ser_out);
    end
    resetn = 1'b1;
    q_m = '0; so_m = 1'b0;
    repeat (3) begin
      tick();
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0 || Q !== 16'h0000) begin
        miscompares++;
        $display("FAIL midrst_idle: done=%b busy=%b Q=%h want 0 0 0000", done, busy, Q);
      end
    end
    do_op("load1234", 3'd1, 0, 16'h1234, 16'h0000, 1'b0);
  endtask

  task automatic test_rotate();
    do_op("load0001", 3'd1, 0, 16'h0001, 16'h0000, 1'b0);
    do_op("rotr", 3'd6, 1, 16'h0000, 16'h0000, 1'b0);
    vectors++;
`ifdef SHIFT_REG_ROTATE_EN
    if (Q !== 16'h8000 || ser_out !== 1'b1) begin
      miscompares++;
      $display("FAIL rotr_const: Q=%h ser_out=%b want 8000 1", Q, ser_out);
    end
`else
    if (Q !== 16'h0001 || ser_out !== 1'b0) begin
      miscompares++;
      $display("FAIL rotr_const: Q=%h ser_out=%b want 0001 0", Q, ser_out);
    end
`endif
  endtask

  task automatic test_random();
    for (int k = 0; k < 80; k++) begin
      do_op("rand", 3'($urandom_range(0, 7)), int'($urandom_range(0, W - 1)),
            W'($urandom), 16'($urandom), bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) tick();
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_shl();
    test_back_to_back();
    test_reset_mid();
    test_rotate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/shift_reg_seq.md
Name: shift_reg_seq

Overview:
- Parametrised successor to the single-bit master-slave D flip-flop: a WIDTH-bit register with parallel load and multi-cycle shift/rotate sequencing.
- Exposes true and complementary outputs, matching the flip-flop's Q/Qnot convention.
- Sits in the 16-bit CPU datapath as the shifter/temporary register.
- Controlled through a start/busy/done handshake.

Parameters:
- WIDTH, 16, register width in bits (>=2).
- AMT_W, $clog2(WIDTH), width of the shift-amount port (derived localparam; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- resetn  input  1  synchronous reset, active-low.
- start  input  1  request; sampled only when busy=0.
- op  input  3  operation code (see Behaviour).
- amt  input  AMT_W  shift count, 0..WIDTH-1.
- D  input  WIDTH  parallel load data.
- ser_in  input  1  serial fill bit for SHL/SHR.
- Q  output  WIDTH  register contents.
- Qnot  output  WIDTH  bitwise ~Q (combinational).
- ser_out  output  1  last bit shifted or rotated out (registered).
- busy  output  1  multi-cycle shift in progress.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Clock and reset:
  - Single clock clk.
  - Reset is synchronous and active-low on resetn.
  - Reset has priority over all other activity at any edge, including mid-shift.
  - Reset values: Q=0, Qnot=all-ones, ser_out=0, busy=0, done=0, state=IDLE, remaining count=0.
- Op codes:
  - 000 HOLD.
  - 001 LOAD.
  - 010 SHL: LSB filled with ser_in.
  - 011 SHR: MSB filled with ser_in.
  - 100 ASR: MSB replicates Q[WIDTH-1].
  - 101 ROTL.
  - 110 ROTR.
  - 111 reserved; behaves as HOLD.
- States: IDLE and SHIFT.
- IDLE, start=1 at edge k:
  - HOLD or reserved: Q unchanged; done=1 for the cycle after edge k; busy stays 0.
  - LOAD: Q<=D at edge k; done=1 for the cycle after edge k; busy stays 0.
  - Shift/rotate with amt=0: same as HOLD (done pulse, Q and ser_out unchanged).
  - Shift/rotate with amt>0: latch op and amt; remaining<=amt; busy<=1; state<=SHIFT. Q is not stepped at edge k.
- SHIFT:
  - At each edge, apply a one-bit step of the latched op to Q.
  - ser_out <= the bit leaving the register (MSB for SHL/ROTL, LSB for SHR/ASR/ROTR).
  - remaining decrements on each step.
  - On the step where remaining==1: state<=IDLE, busy<=0, done<=1.
  - Timing: steps occur at edges k+1..k+amt. busy is high for exactly amt cycles. done is high for the single cycle after edge k+amt.
- ser_in is sampled at every step edge, not only at start.
- start while busy=1 is ignored, with no queuing. A start in the same cycle that done is high is accepted normally (back-to-back operations).
- done is never high for two consecutive cycles from a single request.
- D, amt and op are ignored except at the acceptance edge.
- Qnot tracks Q with no extra latency.

Optional Feature:
- Macro: SHIFT_REG_ROTATE_EN.
- When defined: op 101/110 perform ROTL/ROTR as specified. The rotated-out bit re-enters the opposite end and is also copied to ser_out.
- When undefined: 101/110 decode as reserved, giving HOLD semantics (done pulse, no busy, Q unchanged), and the rotate logic is not synthesised.

Decomposition:
- Shared package shift_reg_pkg:
  - op-code enum/localparams (OP_HOLD…OP_ROTR).
  - state encoding (ST_IDLE, ST_SHIFT).
  - helper function for AMT_W.
- One natural sub-module, shift_reg_step: purely combinational one-bit step.
  - Inputs: Q, op, ser_in.
  - Outputs: next Q and out_bit.
  - Instantiated once in shift_reg_seq; also unit-tested standalone.

Test Plan:
- Reset: hold resetn=0 for 2 edges with start=1, op=LOAD, D=16'hFFFF -> Q=0000, Qnot=FFFF, busy=0, done=0, ser_out=0.
- LOAD: D=16'hA5C3, start 1 cycle -> Q=A5C3 after one edge, Qnot=5A3C, done high exactly 1 cycle, busy never asserted.
- SHL: Q=A5C3, amt=4, ser_in=1 -> busy high 4 cycles, then Q=5C3F, ser_out=0, done 1 cycle; a start pulse in cycle 2 is ignored.
- ASR: Q=8004, amt=3 -> Q=F000, ser_out=1, done in cycle after the 3rd step; a new LOAD start issued the same cycle as done is accepted.
- Reset mid-operation: Q=FFFF, SHR amt=15, ser_in=0; drive resetn=0 at the 5th step -> Q=0000, busy=0, no done. A following LOAD of 1234 completes normally.
- Rotate (macro on): Q=0001, ROTR amt=1 -> Q=8000, ser_out=1. Same stimulus with macro off -> Q stays 0001, done pulse, busy=0.
